matvec_serial_loader: RTL

MATVEC_SERIAL_LOADER -- requirements
Module: matvec_serial_loader

---
 rtl/matvec_pkg.sv | 7 +
 rtl/matvec_serial_loader.sv | 47 ++++
 2 files changed

// File: rtl/matvec_pkg.sv
// matvec_pkg: shared sizing constants and fill-state type for the matvec serial loader
package matvec_pkg;
  localparam int N_DEFAULT = 3;
  localparam int FRAME_BITS = N_DEFAULT * N_DEFAULT + N_DEFAULT;
  localparam int CNT_W = $clog2(FRAME_BITS);
  typedef enum logic {FILLING, COMPLETE} fill_state_t;
endpackage

// File: rtl/matvec_serial_loader.sv
// matvec_serial_loader: deserialises an N*N+N bit frame (A then v) into a double-buffered parallel output for matrix_vec_mul
module matvec_serial_loader
  import matvec_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             s_valid,
  input  logic             s_data,
  output logic             s_ready,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [N*N-1:0]   A,
  output logic [N-1:0]     v
);
  localparam int FB = N * N + N;
  localparam int CW = $clog2(FB);
  fill_state_t state;
  logic [CW-1:0] cnt;
  logic [FB-1:0] fill, out_q;
  logic copy, xfer, last;
  // A completed frame moves to the output when that register is free or draining now
  assign copy = state == COMPLETE && (!m_valid || m_ready);
  assign s_ready = state == FILLING || copy;
  assign xfer = s_valid && s_ready && !flush;
  assign last = cnt == CW'(FB - 1);
  assign A = out_q[N*N-1:0];
  assign v = out_q[FB-1:N*N];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILLING;
      cnt <= '0;
      m_valid <= 1'b0;
      out_q <= '0;
    end else begin
      if (copy) out_q <= fill;
      m_valid <= copy || (m_valid && !m_ready);
      cnt <= flush ? '0 : xfer ? (last ? '0 : cnt + 1'b1) : cnt;
      state <= flush ? FILLING : (xfer && last) ? COMPLETE : copy ? FILLING : state;
    end
  end
  // During a copy cycle the counter is 0, so the accepted bit starts the next frame
  always_ff @(posedge clk)
    if (xfer) fill[cnt] <= s_data;
endmodule
